// File: rtl/vga_pkg.sv
// Shared VGA timing types: per-axis phase encoding and phase helpers.
package vga_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'b00,
    BACK  = 2'b01,
    DISP  = 2'b11,
    FRONT = 2'b10
  } phase_t;

  // Length of a phase in steps for the given per-axis timing.
  function automatic int unsigned phase_len(input phase_t ph,
                                            input int unsigned disp_len,
                                            input int unsigned front_len,
                                            input int unsigned sync_len,
                                            input int unsigned back_len);
    int unsigned len;
    len = sync_len;
    case (ph)
      SYNC:  len = sync_len;
      BACK:  len = back_len;
      DISP:  len = disp_len;
      FRONT: len = front_len;
      default: len = sync_len;
    endcase
    return len;
  endfunction

  function automatic phase_t next_phase(input phase_t ph);
    phase_t nxt;
    nxt = SYNC;
    case (ph)
      SYNC:  nxt = BACK;
      BACK:  nxt = DISP;
      DISP:  nxt = FRONT;
      FRONT: nxt = SYNC;
      default: nxt = SYNC;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_axis_fsm.sv
// One timing axis: SYNC -> BACK -> DISP -> FRONT phase FSM with a per-phase counter.
module vga_axis_fsm
  import vga_pkg::*;
#(
  parameter int unsigned DISP_LEN  = 1280,
  parameter int unsigned FRONT_LEN = 48,
  parameter int unsigned SYNC_LEN  = 112,
  parameter int unsigned BACK_LEN  = 248,
  parameter int unsigned CW        = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_step,
  output logic [1:0]    o_phase,
  output logic [CW-1:0] o_cnt,
  output logic          o_last
);

  localparam logic [63:0] CNT_LIMIT = 64'd1 << CW;

  // Reject zero-length phases and lengths the counter cannot represent.
  if (DISP_LEN == 0 || 64'(DISP_LEN) >= CNT_LIMIT) begin : g_bad_disp
    $error("vga_axis_fsm: DISP_LEN out of range");
  end
  if (FRONT_LEN == 0 || 64'(FRONT_LEN) >= CNT_LIMIT) begin : g_bad_front
    $error("vga_axis_fsm: FRONT_LEN out of range");
  end
  if (SYNC_LEN == 0 || 64'(SYNC_LEN) >= CNT_LIMIT) begin : g_bad_sync
    $error("vga_axis_fsm: SYNC_LEN out of range");
  end
  if (BACK_LEN == 0 || 64'(BACK_LEN) >= CNT_LIMIT) begin : g_bad_back
    $error("vga_axis_fsm: BACK_LEN out of range");
  end

  phase_t        phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last_cnt;

  always_comb begin
    last_cnt = CW'(phase_len(phase, DISP_LEN, FRONT_LEN, SYNC_LEN, BACK_LEN) - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= SYNC;
      cnt   <= '0;
    end else if (i_step) begin
      if (cnt == last_cnt) begin
        phase <= next_phase(phase);
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign o_phase = phase;
  assign o_cnt   = cnt;
  assign o_last  = (phase == FRONT) && (cnt == CW'(FRONT_LEN - 1));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA horizontal/vertical timing generator with pixel enable, sync polarity and strobes.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_DISP  = 1280,
  parameter int unsigned H_FRONT = 48,
  parameter int unsigned H_SYNC  = 112,
  parameter int unsigned H_BACK  = 248,
  parameter int unsigned V_DISP  = 1024,
  parameter int unsigned V_FRONT = 1,
  parameter int unsigned V_SYNC  = 3,
  parameter int unsigned V_BACK  = 38,
  parameter int unsigned H_POL   = 0,
  parameter int unsigned V_POL   = 0,
  parameter int unsigned CW      = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_disp,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_line_end,
  output logic          o_frame_end
);

  logic [1:0]    h_phase_raw, v_phase_raw;
  phase_t        h_phase, v_phase;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_last, v_last;
  logic          v_step;

  // Vertical axis advances once per completed line.
  assign v_step = i_en && h_last;

  vga_axis_fsm #(
    .DISP_LEN (H_DISP),
    .FRONT_LEN(H_FRONT),
    .SYNC_LEN (H_SYNC),
    .BACK_LEN (H_BACK),
    .CW       (CW)
  ) u_h_axis (
    .clk    (clk),
    .rst    (rst),
    .i_step (i_en),
    .o_phase(h_phase_raw),
    .o_cnt  (h_cnt),
    .o_last (h_last)
  );

  vga_axis_fsm #(
    .DISP_LEN (V_DISP),
    .FRONT_LEN(V_FRONT),
    .SYNC_LEN (V_SYNC),
    .BACK_LEN (V_BACK),
    .CW       (CW)
  ) u_v_axis (
    .clk    (clk),
    .rst    (rst),
    .i_step (v_step),
    .o_phase(v_phase_raw),
    .o_cnt  (v_cnt),
    .o_last (v_last)
  );

  assign h_phase = phase_t'(h_phase_raw);
  assign v_phase = phase_t'(v_phase_raw);

  // Zero-latency decode of the axis state.
  assign o_hsync     = (h_phase == SYNC) ? 1'(H_POL) : ~1'(H_POL);
  assign o_vsync     = (v_phase == SYNC) ? 1'(V_POL) : ~1'(V_POL);
  assign o_disp      = (h_phase == DISP) && (v_phase == DISP);
  assign o_x         = (h_phase == DISP) ? h_cnt : '0;
  assign o_y         = (v_phase == DISP) ? v_cnt : '0;
  assign o_line_end  = v_step;
  assign o_frame_end = v_step && v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small timing config, both sync polarities.
module tb_vga_timing_gen;

  localparam int unsigned CW      = 12;
  localparam int unsigned H_SYNC  = 2;
  localparam int unsigned H_BACK  = 1;
  localparam int unsigned H_DISP  = 4;
  localparam int unsigned H_FRONT = 1;
  localparam int unsigned V_SYNC  = 1;
  localparam int unsigned V_BACK  = 1;
  localparam int unsigned V_DISP  = 3;
  localparam int unsigned V_FRONT = 1;
  localparam int unsigned LINE    = H_SYNC + H_BACK + H_DISP + H_FRONT;
  localparam int unsigned VTOT    = V_SYNC + V_BACK + V_DISP + V_FRONT;
  localparam int unsigned FRAME   = LINE * VTOT;

  typedef struct packed {
    logic          hsync;
    logic          vsync;
    logic          disp;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_end;
    logic          frame_end;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_en = 1'b1;

  logic          d_hsync, d_vsync, d_disp, d_line_end, d_frame_end;
  logic [CW-1:0] d_x, d_y;
  logic          p_hsync, p_vsync, p_disp, p_line_end, p_frame_end;
  logic [CW-1:0] p_x, p_y;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_DISP(H_DISP), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISP(V_DISP), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .H_POL(0), .V_POL(0), .CW(CW)
  ) u_dut (
    .clk(clk), .rst(rst), .i_en(i_en),
    .o_hsync(d_hsync), .o_vsync(d_vsync), .o_disp(d_disp),
    .o_x(d_x), .o_y(d_y),
    .o_line_end(d_line_end), .o_frame_end(d_frame_end)
  );

  vga_timing_gen #(
    .H_DISP(H_DISP), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_DISP(V_DISP), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .H_POL(1), .V_POL(1), .CW(CW)
  ) u_pol (
    .clk(clk), .rst(rst), .i_en(i_en),
    .o_hsync(p_hsync), .o_vsync(p_vsync), .o_disp(p_disp),
    .o_x(p_x), .o_y(p_y),
    .o_line_end(p_line_end), .o_frame_end(p_frame_end)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  obs_t        sb_q[$];
  int unsigned t        = 0;
  bit          model_ok = 1'b0;
  obs_t        smp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  // Reference: position derived from the count of enabled steps since reset.
  function automatic obs_t model(input int unsigned tt, input bit en, input bit hpol, input bit vpol);
    obs_t e;
    int unsigned hp, vp;
    bit hd, vd;
    hp = tt % LINE;
    vp = (tt / LINE) % VTOT;
    hd = (hp >= H_SYNC + H_BACK) && (hp < H_SYNC + H_BACK + H_DISP);
    vd = (vp >= V_SYNC + V_BACK) && (vp < V_SYNC + V_BACK + V_DISP);
    e.hsync     = (hp < H_SYNC) ? hpol : ~hpol;
    e.vsync     = (vp < V_SYNC) ? vpol : ~vpol;
    e.disp      = hd && vd;
    e.x         = hd ? CW'(hp - H_SYNC - H_BACK) : '0;
    e.y         = vd ? CW'(vp - V_SYNC - V_BACK) : '0;
    e.line_end  = en && (hp == LINE - 1);
    e.frame_end = e.line_end && (vp == VTOT - 1);
    return e;
  endfunction

  task automatic cmp(input string who, input obs_t o, input obs_t e);
    check({who, ".hsync"},     32'(o.hsync),     32'(e.hsync));
    check({who, ".vsync"},     32'(o.vsync),     32'(e.vsync));
    check({who, ".disp"},      32'(o.disp),      32'(e.disp));
    check({who, ".x"},         32'(o.x),         32'(e.x));
    check({who, ".y"},         32'(o.y),         32'(e.y));
    check({who, ".line_end"},  32'(o.line_end),  32'(e.line_end));
    check({who, ".frame_end"}, 32'(o.frame_end), 32'(e.frame_end));
  endtask

  // One clock: drive inputs, score outputs at negedge, then advance the model.
  task automatic tick(input bit r, input bit en);
    obs_t e, o;
    rst  = r;
    i_en = en;
    @(negedge clk);
    smp = {d_hsync, d_vsync, d_disp, d_x, d_y, d_line_end, d_frame_end};
    if (model_ok) begin
      sb_q.push_back(model(t, en, 1'b0, 1'b0));
      sb_q.push_back(model(t, en, 1'b1, 1'b1));
      e = sb_q.pop_front();
      cmp("dut", smp, e);
      e = sb_q.pop_front();
      o = {p_hsync, p_vsync, p_disp, p_x, p_y, p_line_end, p_frame_end};
      cmp("pol", o, e);
    end
    @(posedge clk);
    #1;
    if (r) begin
      t = 0;
      model_ok = 1'b1;
    end else if (en) begin
      t = (t + 1) % FRAME;
    end
  endtask

  // Runs from reset release; checks first-pixel cycle and strobe placement over one frame.
  task automatic run_frame_from_release(input string tag);
    int first_disp = -1;
    int n_le = 0, n_fe = 0, fe_cyc = -1;
    for (int c = 0; c < 50; c++) begin
      tick(1'b0, 1'b1);
      if (smp.disp && first_disp < 0) first_disp = c;
      if (c < 48 && smp.line_end) begin
        n_le++;
        check({tag, ".line_end_cycle"}, 32'(c % LINE), 32'(LINE - 1));
      end
      if (c < 48 && smp.frame_end) begin
        n_fe++;
        fe_cyc = c;
      end
      if (c == 48) begin
        check({tag, ".wrap_hsync"}, 32'(smp.hsync), 32'd0);
        check({tag, ".wrap_vsync"}, 32'(smp.vsync), 32'd0);
      end
    end
    check({tag, ".first_disp_cycle"}, 32'(first_disp), 32'd19);
    check({tag, ".line_end_count"},   32'(n_le),       32'd6);
    check({tag, ".frame_end_count"},  32'(n_fe),       32'd1);
    check({tag, ".frame_end_cycle"},  32'(fe_cyc),     32'd47);
  endtask

  initial begin
    bit found;

    // Reset release and one full frame plus wrap.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1);
      if (i > 0) begin
        check("rst.hsync", 32'(smp.hsync), 32'd0);
        check("rst.disp",  32'(smp.disp),  32'd0);
      end
    end
    run_frame_from_release("release");

    // Enable gating while o_x == 2.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (d_disp && d_x == CW'(2)) found = 1'b1;
      else tick(1'b0, 1'b1);
    end
    check("gate.wait_x2", 32'(found), 32'd1);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0);
      check("gate.x_frozen",   32'(smp.x),        32'd2);
      check("gate.no_line_end", 32'(smp.line_end), 32'd0);
    end
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("gate.x_after", 32'(smp.x), 32'd3);

    // Mid-frame reset at o_y == 1, o_x == 1.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (d_disp && d_x == CW'(1) && d_y == CW'(1)) found = 1'b1;
      else tick(1'b0, 1'b1);
    end
    check("midrst.wait_pos", 32'(found), 32'd1);
    tick(1'b1, 1'b1);
    check("midrst.hsync", 32'(d_hsync), 32'd0);
    check("midrst.x",     32'(d_x),     32'd0);
    run_frame_from_release("midrst");

    // Random enable pattern with occasional resets.
    for (int i = 0; i < 300; i++) begin
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
